// File: rtl/pwm_hbridge_if.sv
// Register-side controls and bridge-side pins of one H-bridge PWM channel.
// master drives the controls and watches the pins; slave is the channel itself.
interface pwm_hbridge_if #(
    parameter int WIDTH   = 8,
    parameter int DTWIDTH = 4
);
    logic               pwmcntce;
    logic               pwmldce;
    logic [WIDTH-1:0]   wrtdata;
    logic               centermode;
    logic               invertpwm;
    logic               enablepwm;
    logic               run;
    logic               currentlimit;
    logic [DTWIDTH-1:0] dtval;
    logic [1:0]         pwmout;
    logic               cycstart;
    logic               climited;

    modport master (
        output pwmcntce, pwmldce, wrtdata, centermode, invertpwm,
               enablepwm, run, currentlimit, dtval,
        input  pwmout, cycstart, climited
    );

    modport slave (
        input  pwmcntce, pwmldce, wrtdata, centermode, invertpwm,
               enablepwm, run, currentlimit, dtval,
        output pwmout, cycstart, climited
    );
endinterface

// File: rtl/pwm_hbridge.sv
// H-bridge PWM channel: edge/center counter, shadowed duty, cycle-by-cycle
// current limit and a registered deadtime engine driving the bridge pins.
module pwm_hbridge #(
    parameter int WIDTH   = 8,
    parameter int DTWIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_hbridge_if.slave   bus
);
    localparam logic [WIDTH-1:0]   MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   HALF   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DTWIDTH-1:0] DT_ONE = {{(DTWIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]   duty_q, duty_d;
    logic               down_q, down_d;
    logic               center_q, center_d;
    logic               clim_q, clim_d;
    logic               pwmq_q, pwmq_d;
    logic               cycstart_q, cycstart_d;
    logic [1:0]         tlast_q, tlast_d;
    logic [1:0]         pwmout_q, pwmout_d;
    logic [DTWIDTH-1:0] dt_q, dt_d;
    logic               start;
    logic               raw;
    logic               pol;
    logic [1:0]         target;

    // center_q is the counting mode actually in force; centermode is only
    // sampled at a period start so a period is never split between modes.
    always_comb begin
        start    = bus.pwmcntce && (center_q ? (down_q && count_q == ONE)
                                             : (count_q == MAX));
        count_d  = count_q;
        down_d   = down_q;
        center_d = center_q;
        if (start) begin
            count_d  = '0;
            down_d   = 1'b0;
            center_d = bus.centermode;
        end else if (bus.pwmcntce) begin
            if (!center_q) begin
                count_d = count_q + ONE;
            end else if (!down_q) begin
                if (count_q == MAX) begin
                    count_d = count_q - ONE;
                    down_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else if (count_q == '0) begin
                count_d = ONE;
                down_d  = 1'b0;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_comb begin
        pend_d     = bus.pwmldce ? bus.wrtdata : pend_q;
        duty_d     = start ? pend_q : duty_q;
        raw        = (count_q < duty_q) && !clim_q;
        clim_d     = start ? 1'b0 : (clim_q | (bus.currentlimit & raw));
        pwmq_d     = raw;
        cycstart_d = start;
    end

    // Coast is always safe, so it bypasses deadtime; any other change of
    // target restarts the blanking interval.
    always_comb begin
        pol = pwmq_q ^ bus.invertpwm;
        if (!bus.run) begin
            target = 2'b11;
        end else if (bus.enablepwm) begin
            target = {~pol, pol};
        end else begin
            target = 2'b00;
        end
        tlast_d  = tlast_q;
        dt_d     = dt_q;
        pwmout_d = 2'b00;
        if (target == 2'b00) begin
            dt_d = '0;
        end else if (target != tlast_q) begin
            tlast_d  = target;
            dt_d     = bus.dtval;
            pwmout_d = (bus.dtval == '0) ? target : 2'b00;
        end else if (dt_q != '0) begin
            dt_d = dt_q - DT_ONE;
        end else begin
            pwmout_d = tlast_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            down_q     <= 1'b0;
            center_q   <= 1'b0;
            pend_q     <= HALF;
            duty_q     <= HALF;
            clim_q     <= 1'b0;
            pwmq_q     <= 1'b0;
            cycstart_q <= 1'b0;
            tlast_q    <= 2'b00;
            dt_q       <= '0;
            pwmout_q   <= 2'b00;
        end else begin
            count_q    <= count_d;
            down_q     <= down_d;
            center_q   <= center_d;
            pend_q     <= pend_d;
            duty_q     <= duty_d;
            clim_q     <= clim_d;
            pwmq_q     <= pwmq_d;
            cycstart_q <= cycstart_d;
            tlast_q    <= tlast_d;
            dt_q       <= dt_d;
            pwmout_q   <= pwmout_d;
        end
    end

    assign bus.pwmout   = pwmout_q;
    assign bus.cycstart = cycstart_q;
    assign bus.climited = clim_q;
endmodule

// File: tb/tb_pwm_hbridge.sv
// Scoreboard bench for pwm_hbridge: a period-position reference model pushes
// the expected pins for every clock, a monitor pops and compares them.
module tb_pwm_hbridge;
    localparam int W    = 8;
    localparam int DW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_hbridge_if #(.WIDTH(W), .DTWIDTH(DW)) bus ();
    pwm_hbridge #(.WIDTH(W), .DTWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stimulus for the next clock edge
    int s_rst = 0, s_cntce = 1, s_ld = 0, s_wd = 0, s_center = 0, s_inv = 0;
    int s_en = 1, s_run = 1, s_cl = 0, s_dt = 0;

    // reference model: position inside the period instead of a counter
    int m_pos, m_center, m_duty, m_pend, m_clim, m_pwm, m_tlast, m_dt, m_out, m_cyc;

    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;
    int prev_rst = 0;

    function automatic void model_reset();
        m_pos = 0; m_center = 0; m_duty = 1 << (W - 1); m_pend = 1 << (W - 1);
        m_clim = 0; m_pwm = 0; m_tlast = 0; m_dt = 0; m_out = 0; m_cyc = 0;
    endfunction

    function automatic void model_step();
        int cnt, plen, start, raw, pol, tgt;
        cnt   = (!m_center || m_pos <= MAXV) ? m_pos : 2 * MAXV - m_pos;
        plen  = m_center ? 2 * MAXV : MAXV + 1;
        start = (s_cntce != 0 && m_pos == plen - 1) ? 1 : 0;
        raw   = (cnt < m_duty && m_clim == 0) ? 1 : 0;
        pol   = m_pwm ^ s_inv;
        tgt   = (s_run == 0) ? 3 : (s_en != 0 ? (pol != 0 ? 1 : 2) : 0);
        if (tgt == 0) begin
            m_out = 0; m_dt = 0;
        end else if (tgt != m_tlast) begin
            m_tlast = tgt; m_dt = s_dt; m_out = (s_dt == 0) ? tgt : 0;
        end else if (m_dt != 0) begin
            m_dt = m_dt - 1; m_out = 0;
        end else begin
            m_out = m_tlast;
        end
        m_cyc  = start;
        m_clim = start ? 0 : ((m_clim != 0 || (s_cl != 0 && raw != 0)) ? 1 : 0);
        m_pwm  = raw;
        if (start != 0) begin
            m_duty = m_pend; m_center = s_center; m_pos = 0;
        end else if (s_cntce != 0) begin
            m_pos = m_pos + 1;
        end
        if (s_ld != 0) m_pend = s_wd;
    endfunction

    task automatic step();
        logic [3:0] act;
        @(negedge clk);
        bus.pwmcntce     = s_cntce[0];
        bus.pwmldce      = s_ld[0];
        bus.wrtdata      = s_wd[W-1:0];
        bus.centermode   = s_center[0];
        bus.invertpwm    = s_inv[0];
        bus.enablepwm    = s_en[0];
        bus.run          = s_run[0];
        bus.currentlimit = s_cl[0];
        bus.dtval        = s_dt[DW-1:0];
        rst_n            = s_rst[0];
        if (s_rst == 0) begin
            if (prev_rst != 0) begin
                #1;
                act = {bus.pwmout, bus.cycstart, bus.climited};
                n_checks++;
                if (act !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL async_reset t=%0t actual pins=%b required 0000", $time, act);
                end
            end
            model_reset();
            exp_q.push_back(4'b0000);
        end else begin
            model_step();
            exp_q.push_back(4'((m_out << 2) | (m_cyc << 1) | m_clim));
        end
        prev_rst = s_rst;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int p, input int lim);
        int k = 0;
        while (m_pos != p && k < lim) begin
            step();
            k++;
        end
        n_checks++;
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL wait_pos actual pos=%0d required pos=%0d", m_pos, p);
        end
    endtask

    task automatic write_duty(input int d);
        s_ld = 1; s_wd = d;
        step();
        s_ld = 0;
    endtask

    // monitor: compare one expected entry per clock edge
    initial begin
        logic [3:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bus.pwmout, bus.cycstart, bus.climited};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    if (n_print < 20) begin
                        n_print++;
                        $display("FAIL pins t=%0t actual pwmout=%b cyc=%b clim=%b required pwmout=%b cyc=%b clim=%b",
                                 $time, a[3:2], a[1], a[0], e[3:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        // reset and default duty
        run_n(3);
        s_rst = 1;
        run_n(600);
        $display("phase 1 reset/default duty: checks=%0d failures=%0d", n_checks, n_fail);
        // shadow updates written mid-period
        wait_pos(10, 300); write_duty(64);  run_n(600);
        wait_pos(10, 300); write_duty(0);   run_n(600);
        wait_pos(10, 300); write_duty(255); run_n(600);
        $display("phase 2 shadow duty: checks=%0d failures=%0d", n_checks, n_fail);
        // deadtime, including a pulse shorter than the deadtime
        s_dt = 5; write_duty(128); run_n(600);
        write_duty(3); run_n(600);
        $display("phase 3 deadtime: checks=%0d failures=%0d", n_checks, n_fail);
        // one-clock overcurrent pulse
        write_duty(128); run_n(300);
        wait_pos(20, 300);
        s_cl = 1; step(); s_cl = 0;
        run_n(600);
        $display("phase 4 current limit: checks=%0d failures=%0d", n_checks, n_fail);
        // center-aligned counting
        s_dt = 0; s_center = 1; write_duty(64); run_n(1600);
        $display("phase 5 center mode: checks=%0d failures=%0d", n_checks, n_fail);
        // bridge states and asynchronous reset
        s_center = 0; run_n(600);
        s_dt = 7; s_run = 0; run_n(20);
        s_run = 1; s_en = 0; run_n(5);
        s_inv = 1; s_en = 1; run_n(600);
        s_dt = 10; s_run = 0; run_n(4);
        s_rst = 0; step(); run_n(3);
        s_rst = 1; run_n(30);
        s_run = 0; run_n(30);
        s_rst = 0; step(); run_n(2);
        s_rst = 1; s_run = 1; s_inv = 0; run_n(300);
        $display("phase 6 bridge states/async reset: checks=%0d failures=%0d", n_checks, n_fail);
        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            s_cntce = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_ld    = ($urandom_range(0, 39) == 0) ? 1 : 0;
            case ($urandom_range(0, 3))
                0:       s_wd = 0;
                1:       s_wd = MAXV;
                default: s_wd = $urandom_range(0, MAXV);
            endcase
            s_cl = ($urandom_range(0, 49) == 0) ? 1 : 0;
            if (i % 500 == 0) begin
                s_center = $urandom_range(0, 1);
                s_inv    = $urandom_range(0, 1);
                s_dt     = $urandom_range(0, (1 << DW) - 1);
            end
            if ($urandom_range(0, 299) == 0) s_en = 1 - s_en;
            if ($urandom_range(0, 399) == 0) s_run = 1 - s_run;
            step();
        end
        $display("phase 7 random: checks=%0d failures=%0d", n_checks, n_fail);
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
